// File: rtl/ram_sync_clr.sv
// ---------------------------------------------------------------------------
// ram_sync_clr
//
// Parametrised single-port synchronous data RAM with a hardware clear
// sequencer. After reset (or on a clr request) the sequencer owns the array
// and writes zero to every word, one word per cycle, while busy is high.
// Once the sweep completes the RAM accepts user reads and writes.
//
// Parameters:
//   WIDTH     - data word width in bits
//   ADDR_W    - address width; depth is 2**ADDR_W words
//   READ_MODE - same-address read-during-write: 0 = read-first (old data),
//               1 = write-first (returns in)
//
// Ports:
//   clk       in   system clock, rising-edge active
//   reset     in   synchronous active-high reset; restarts the clear sweep
//   in        in   write data
//   load      in   write enable
//   address   in   word address shared by reads and writes
//   rd_en     in   read request
//   clr       in   single-cycle request to re-zero the whole array
//   out       out  registered read data (cleared only by reset)
//   out_valid out  high for one cycle when out carries fresh read data
//   busy      out  high while the clear sequencer owns the array
//
// Optional build macro:
//   RAM_SYNC_CLR_OUTREG_EN - adds a second output register stage, making the
//   read latency 2 cycles. clr and reset flush the in-flight valid.
// ---------------------------------------------------------------------------
module ram_sync_clr #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 14,
  parameter int READ_MODE = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  in,
  input  logic              load,
  input  logic [ADDR_W-1:0] address,
  input  logic              rd_en,
  input  logic              clr,
  output logic [WIDTH-1:0]  out,
  output logic              out_valid,
  output logic              busy
);

  localparam int                DEPTH     = 2 ** ADDR_W;
  // DEPTH is a power of two, so the last address is all ones.
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] ZERO_ADDR = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ONE_ADDR  = ADDR_W'(1'b1);
  localparam logic [WIDTH-1:0]  ZERO_WORD = {WIDTH{1'b0}};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] clr_addr_r;
  logic              busy_r;

  logic [WIDTH-1:0]  mem_r [DEPTH];

  logic              clr_take_s;
  logic              rd_fire_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [WIDTH-1:0]  mem_wdata_s;
  logic [WIDTH-1:0]  rd_data_s;

  logic [WIDTH-1:0]  rd_out_r;
  logic              rd_valid_r;

  // User-side request qualification: only honoured in READY, clr wins.
  always_comb begin
    clr_take_s = 1'b0;
    rd_fire_s  = 1'b0;
    if (!reset && (state_r == READY)) begin
      clr_take_s = clr;
      rd_fire_s  = rd_en & ~clr;
    end else begin
      clr_take_s = 1'b0;
      rd_fire_s  = 1'b0;
    end
  end

  // Array write-port mux: sweep owns the port in CLEAR, user load in READY.
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = ZERO_ADDR;
    mem_wdata_s = ZERO_WORD;
    if (reset) begin
      // No array write while reset is held.
      mem_we_s = 1'b0;
    end else if (state_r == CLEAR) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = clr_addr_r;
      mem_wdata_s = ZERO_WORD;
    end else if (clr) begin
      // clr drops a coincident load.
      mem_we_s = 1'b0;
    end else if (load) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = address;
      mem_wdata_s = in;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Read-data source: the array read happens before the edge, so it yields
  // pre-write contents (read-first) unless write-first forwarding applies.
  always_comb begin
    rd_data_s = mem_r[address];
    if ((READ_MODE == 1) && load) begin
      rd_data_s = in;
    end else begin
      rd_data_s = mem_r[address];
    end
  end

  // Clear sequencer FSM: owns clr_addr, state and busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= CLEAR;
      clr_addr_r <= ZERO_ADDR;
      busy_r     <= 1'b1;
    end else begin
      case (state_r)
        CLEAR: begin
          if (clr_addr_r == LAST_ADDR) begin
            // Final word is written this edge; hold clr_addr, never wrap.
            state_r <= READY;
            busy_r  <= 1'b0;
          end else begin
            clr_addr_r <= clr_addr_r + ONE_ADDR;
          end
        end
        READY: begin
          if (clr) begin
            state_r    <= CLEAR;
            clr_addr_r <= ZERO_ADDR;
            busy_r     <= 1'b1;
          end else begin
            state_r <= READY;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r    <= CLEAR;
          clr_addr_r <= ZERO_ADDR;
          busy_r     <= 1'b1;
        end
      endcase
    end
  end

  // Storage array; reset-free so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // First output stage: out holds unless a read fires; valid is a pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_out_r   <= ZERO_WORD;
      rd_valid_r <= 1'b0;
    end else if (rd_fire_s) begin
      rd_out_r   <= rd_data_s;
      rd_valid_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
    end
  end

`ifdef RAM_SYNC_CLR_OUTREG_EN
  logic [WIDTH-1:0] pipe_out_r;
  logic             pipe_valid_r;

  // Second output stage; an accepted clr flushes the in-flight read.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_out_r   <= ZERO_WORD;
      pipe_valid_r <= 1'b0;
    end else if (clr_take_s) begin
      pipe_valid_r <= 1'b0;
    end else if (rd_valid_r) begin
      pipe_out_r   <= rd_out_r;
      pipe_valid_r <= 1'b1;
    end else begin
      pipe_valid_r <= 1'b0;
    end
  end

  assign out       = pipe_out_r;
  assign out_valid = pipe_valid_r;
`else
  // clr_take_s only matters for the optional second stage; in this build the
  // first stage already drops valid through rd_fire_s.
  logic unused_clr_take_s;
  assign unused_clr_take_s = clr_take_s;

  assign out       = rd_out_r;
  assign out_valid = rd_valid_r;
`endif

  assign busy = busy_r;

endmodule

// File: tb/tb_ram_sync_clr.sv
// ---------------------------------------------------------------------------
// tb_ram_sync_clr
//
// Directed bench for ram_sync_clr with ADDR_W=4, WIDTH=16. Two instances
// share every input: one read-first (READ_MODE=0), one write-first
// (READ_MODE=1). Inputs change 1 ns after the rising edge and outputs are
// sampled at the same point, so each step() shows the result of one edge.
// ---------------------------------------------------------------------------
module tb_ram_sync_clr;

  logic        clk;
  logic        reset;
  logic [15:0] in;
  logic        load;
  logic [3:0]  address;
  logic        rd_en;
  logic        clr;

  logic [15:0] out_rf;
  logic        valid_rf;
  logic        busy_rf;
  logic [15:0] out_wf;
  logic        valid_wf;
  logic        busy_wf;

  int pass_cnt;
  int total_cnt;

  ram_sync_clr #(.WIDTH(16), .ADDR_W(4), .READ_MODE(0)) dut_rf (
    .clk(clk), .reset(reset), .in(in), .load(load), .address(address),
    .rd_en(rd_en), .clr(clr), .out(out_rf), .out_valid(valid_rf), .busy(busy_rf)
  );

  ram_sync_clr #(.WIDTH(16), .ADDR_W(4), .READ_MODE(1)) dut_wf (
    .clk(clk), .reset(reset), .in(in), .load(load), .address(address),
    .rd_en(rd_en), .clr(clr), .out(out_wf), .out_valid(valid_wf), .busy(busy_wf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [15:0] d);
    address = a;
    in      = d;
    load    = 1'b1;
    step();
    load    = 1'b0;
  endtask

  // Issue one read and wait out the read latency.
  task automatic read_addr(input logic [3:0] a);
    address = a;
    rd_en   = 1'b1;
    step();
    rd_en   = 1'b0;
`ifdef RAM_SYNC_CLR_OUTREG_EN
    step();
`endif
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    step();
    step();
    total_cnt++;
    if (busy_rf !== 1'b1 || out_rf !== 16'h0000 || valid_rf !== 1'b0 || out_wf !== 16'h0000) begin
      $display("FAIL reset_state busy=%b out=%h valid=%b out_wf=%h required busy=1 out=0000 valid=0",
               busy_rf, out_rf, valid_rf, out_wf);
    end else pass_cnt++;
    reset = 1'b0;
    n = 0;
    while (busy_rf === 1'b1 && n < 40) begin
      step();
      n++;
    end
    total_cnt++;
    if (n !== 16 || busy_wf !== 1'b0) begin
      $display("FAIL reset_busy_len cycles=%0d busy_wf=%b required 16 and 0", n, busy_wf);
    end else pass_cnt++;
    for (int a = 0; a < 16; a++) begin
      read_addr(4'(a));
      total_cnt++;
      if (out_rf !== 16'h0000 || valid_rf !== 1'b1 || out_wf !== 16'h0000) begin
        $display("FAIL reset_read0 addr=%0d out=%h valid=%b out_wf=%h required 0000 1 0000",
                 a, out_rf, valid_rf, out_wf);
      end else pass_cnt++;
    end
  endtask

  task automatic test_write_read();
    write_word(4'd5, 16'hBEEF);
    read_addr(4'd5);
    total_cnt++;
    if (out_rf !== 16'hBEEF || valid_rf !== 1'b1 || out_wf !== 16'hBEEF) begin
      $display("FAIL wr_rd out=%h valid=%b out_wf=%h required beef 1 beef", out_rf, valid_rf, out_wf);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (out_rf !== 16'hBEEF || valid_rf !== 1'b0) begin
      $display("FAIL wr_rd_idle out=%h valid=%b required beef 0", out_rf, valid_rf);
    end else pass_cnt++;
  endtask

  task automatic test_rdw();
    write_word(4'd3, 16'h1111);
    address = 4'd3;
    in      = 16'h2222;
    load    = 1'b1;
    rd_en   = 1'b1;
    step();
    load    = 1'b0;
    rd_en   = 1'b0;
`ifdef RAM_SYNC_CLR_OUTREG_EN
    step();
`endif
    total_cnt++;
    if (out_rf !== 16'h1111 || valid_rf !== 1'b1) begin
      $display("FAIL rdw_read_first out=%h valid=%b required 1111 1", out_rf, valid_rf);
    end else pass_cnt++;
    total_cnt++;
    if (out_wf !== 16'h2222 || valid_wf !== 1'b1) begin
      $display("FAIL rdw_write_first out=%h valid=%b required 2222 1", out_wf, valid_wf);
    end else pass_cnt++;
    read_addr(4'd3);
    total_cnt++;
    if (out_rf !== 16'h2222 || out_wf !== 16'h2222) begin
      $display("FAIL rdw_after out_rf=%h out_wf=%h required 2222 2222", out_rf, out_wf);
    end else pass_cnt++;
  endtask

  task automatic test_clear_priority();
    int n;
    for (int a = 0; a < 16; a++) write_word(4'(a), 16'hA5A5);
    read_addr(4'd7);
    total_cnt++;
    if (out_rf !== 16'hA5A5 || busy_rf !== 1'b0) begin
      $display("FAIL fill_read out=%h busy=%b required a5a5 0", out_rf, busy_rf);
    end else pass_cnt++;
    clr     = 1'b1;
    load    = 1'b1;
    in      = 16'hFFFF;
    address = 4'd0;
    step();
    clr     = 1'b0;
    load    = 1'b0;
    total_cnt++;
    if (busy_rf !== 1'b1 || valid_rf !== 1'b0) begin
      $display("FAIL clr_busy_rise busy=%b valid=%b required 1 0", busy_rf, valid_rf);
    end else pass_cnt++;
    n = 0;
    while (busy_rf === 1'b1 && n < 40) begin
      step();
      n++;
    end
    total_cnt++;
    if (n !== 16) begin
      $display("FAIL clr_busy_len cycles=%0d required 16", n);
    end else pass_cnt++;
    total_cnt++;
    if (out_rf !== 16'hA5A5) begin
      $display("FAIL clr_out_hold out=%h required a5a5", out_rf);
    end else pass_cnt++;
    for (int a = 0; a < 16; a++) begin
      read_addr(4'(a));
      total_cnt++;
      if (out_rf !== 16'h0000 || valid_rf !== 1'b1 || out_wf !== 16'h0000) begin
        $display("FAIL clr_read0 addr=%0d out=%h valid=%b out_wf=%h required 0000 1 0000",
                 a, out_rf, valid_rf, out_wf);
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_clear();
    int n;
    int bad;
    clr = 1'b1;
    step();
    clr = 1'b0;
    bad = 0;
    for (int i = 0; i < 7; i++) begin
      address = 4'd6;
      in      = 16'h7777;
      load    = 1'b1;
      rd_en   = 1'b1;
      step();
      if (valid_rf !== 1'b0 || busy_rf !== 1'b1) bad++;
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if (bad !== 0 || busy_rf !== 1'b1 || out_rf !== 16'h0000 || valid_rf !== 1'b0) begin
      $display("FAIL midclr_reset bad=%0d busy=%b out=%h valid=%b required 0 1 0000 0",
               bad, busy_rf, out_rf, valid_rf);
    end else pass_cnt++;
    n   = 0;
    bad = 0;
    while (busy_rf === 1'b1 && n < 40) begin
      step();
      n++;
      if (valid_rf !== 1'b0 || valid_wf !== 1'b0) bad++;
    end
    load  = 1'b0;
    rd_en = 1'b0;
    total_cnt++;
    if (n !== 16 || bad !== 0) begin
      $display("FAIL midclr_restart cycles=%0d valid_seen=%0d required 16 0", n, bad);
    end else pass_cnt++;
    read_addr(4'd6);
    total_cnt++;
    if (out_rf !== 16'h0000 || out_wf !== 16'h0000 || valid_rf !== 1'b1) begin
      $display("FAIL midclr_nowrite out=%h out_wf=%h valid=%b required 0000 0000 1",
               out_rf, out_wf, valid_rf);
    end else pass_cnt++;
  endtask

`ifdef RAM_SYNC_CLR_OUTREG_EN
  task automatic test_outreg();
    int n;
    write_word(4'd9, 16'h00C3);
    address = 4'd9;
    rd_en   = 1'b1;
    step();
    rd_en   = 1'b0;
    total_cnt++;
    if (valid_rf !== 1'b0) begin
      $display("FAIL outreg_early valid=%b required 0", valid_rf);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (out_rf !== 16'h00C3 || valid_rf !== 1'b1) begin
      $display("FAIL outreg_lat2 out=%h valid=%b required 00c3 1", out_rf, valid_rf);
    end else pass_cnt++;
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    clr   = 1'b1;
    step();
    clr   = 1'b0;
    total_cnt++;
    if (valid_rf !== 1'b0 || valid_wf !== 1'b0) begin
      $display("FAIL outreg_flush valid=%b valid_wf=%b required 0 0", valid_rf, valid_wf);
    end else pass_cnt++;
    n = 0;
    while (busy_rf === 1'b1 && n < 40) begin
      step();
      n++;
    end
    total_cnt++;
    if (n !== 16) begin
      $display("FAIL outreg_sweep cycles=%0d required 16", n);
    end else pass_cnt++;
  endtask
`else
  task automatic test_back_to_back();
    write_word(4'd5, 16'hBEEF);
    write_word(4'd3, 16'h2222);
    address = 4'd5;
    rd_en   = 1'b1;
    step();
    total_cnt++;
    if (out_rf !== 16'hBEEF || valid_rf !== 1'b1) begin
      $display("FAIL b2b_first out=%h valid=%b required beef 1", out_rf, valid_rf);
    end else pass_cnt++;
    address = 4'd3;
    step();
    rd_en   = 1'b0;
    total_cnt++;
    if (out_rf !== 16'h2222 || valid_rf !== 1'b1) begin
      $display("FAIL b2b_second out=%h valid=%b required 2222 1", out_rf, valid_rf);
    end else pass_cnt++;
    step();
    total_cnt++;
    if (out_rf !== 16'h2222 || valid_rf !== 1'b0) begin
      $display("FAIL b2b_idle out=%h valid=%b required 2222 0", out_rf, valid_rf);
    end else pass_cnt++;
  endtask
`endif

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    reset     = 1'b1;
    in        = 16'h0000;
    load      = 1'b0;
    address   = 4'd0;
    rd_en     = 1'b0;
    clr       = 1'b0;
    test_reset();
    test_write_read();
    test_rdw();
    test_clear_priority();
    test_reset_mid_clear();
`ifdef RAM_SYNC_CLR_OUTREG_EN
    test_outreg();
`else
    test_back_to_back();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
